div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/calc_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/div_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator mode controllers: the FSM state
// type and the default operand width.
package calc_pkg;

    // Default operand/result width used by the mode controllers
    localparam int CALC_W = 8;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } calc_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and shift the
// resulting quotient bit into the dividend register.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] dvd,
    input  logic [W-1:0] dvs,
    output logic [W:0]   rem_next,
    output logic [W-1:0] dvd_next
);

    logic [W+1:0] t;
    logic         ge;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and widening t by that bit leaves the compare unchanged.
    always_comb begin
        t  = {rem, dvd[W-1]};
        ge = (t >= {2'b00, dvs});
        if (ge) begin
            rem_next = t[W:0] - {1'b0, dvs};
        end else begin
            rem_next = t[W:0];
        end
        dvd_next = {dvd[W-2:0], ge};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle unsigned divider controller for the calculator.
// Takes one quotient bit per cycle, reports divide-by-zero immediately.
// Optional macro DIV_REM_EN adds the remainder output port r.
module div_ctrl
    import calc_pkg::*;
#(
    parameter int W = CALC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
`ifdef DIV_REM_EN
    output logic [W-1:0] r,
`endif
    output logic         busy,
    output logic         done,
    output logic         v
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    calc_state_t   state;
    calc_state_t   state_next;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W:0]    rem;
    logic [CW-1:0] cnt;
    logic [W:0]    rem_next;
    logic [W-1:0]  dvd_next;

    div_step #(.W(W)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dvs      (dvs),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start requests only count in IDLE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (div_) begin
                    state_next = (b != '0) ? ST_ITER : ST_FIN;
                end
            end
            ST_ITER: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load operands, iterate, and capture results on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            q   <= '0;
            v   <= 1'b0;
`ifdef DIV_REM_EN
            r   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_) begin
                        if (b != '0) begin
                            dvd <= a;
                            dvs <= b;
                            rem <= '0;
                            cnt <= CW'(W - 1);
                        end else begin
                            q <= '1;
                            v <= 1'b1;
`ifdef DIV_REM_EN
                            r <= a;
`endif
                        end
                    end
                end
                ST_ITER: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    if (cnt == '0) begin
                        q <= dvd_next;
                        v <= 1'b0;
`ifdef DIV_REM_EN
                        r <= rem_next[W-1:0];
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
